// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate request scheduler.
//   DEF_N / DEF_NREQ : default data width and requester count
//   SW / IW          : rotate-amount and requester-ID widths for the defaults
//   DIR_LEFT/RIGHT   : encoding of the per-request dir bit
//   sched_state_t    : result-register occupancy
package rotate_pkg;
    localparam int DEF_N    = 8;
    localparam int DEF_NREQ = 4;
    localparam int SW       = $clog2(DEF_N);
    localparam int IW       = $clog2(DEF_NREQ);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } sched_state_t;
endpackage

// File: rtl/barrel_shifter_rotate.sv
// Combinational N-bit rotator.
//   din    : word to rotate
//   sh_amt : rotate distance (SW bits, so implicitly modulo N)
//   dir    : DIR_LEFT or DIR_RIGHT
//   dout   : rotated word
module barrel_shifter_rotate
    import rotate_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  din,
    input  logic [SW-1:0] sh_amt,
    input  logic          dir,
    output logic [N-1:0]  dout
);
    // Shifting a doubled copy makes the wrap-around bits fall into the kept half.
    logic [2*N-1:0] dbl_l, dbl_r;

    assign dbl_l = {din, din} << sh_amt;
    assign dbl_r = {din, din} >> sh_amt;
    assign dout  = (dir == DIR_RIGHT) ? dbl_r[N-1:0] : dbl_l[2*N-1:N];
endmodule

// File: rtl/rotate_req_scheduler.sv
// Round-robin scheduler sharing one rotator between NREQ requesters.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester command handshake (ready is one-hot or zero)
//   req_din/sh_amt/dir    : packed per-requester command fields
//   out_valid/out_ready   : result handshake to the single consumer
//   out_dout/out_id       : rotated word and the requester that produced it
module rotate_req_scheduler
    import rotate_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    localparam int SHW = $clog2(N),
    localparam int IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_din,
    input  logic [NREQ*SHW-1:0] req_sh_amt,
    input  logic [NREQ-1:0]    req_dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_dout,
    output logic [IDW-1:0]     out_id
);
    sched_state_t   state, state_nxt;
    logic [IDW-1:0] rr_ptr, grant;
    logic           found, slot_free, accept;
    logic [N-1:0]   sel_din, rot_dout;
    logic [SHW-1:0] sel_sh;
    logic           sel_dir;

    // Search starting at rr_ptr; IDW-bit addition wraps modulo NREQ.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            logic [IDW-1:0] idx;
            idx = rr_ptr + IDW'(k);
            if (!found && req_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign slot_free = (state == ST_EMPTY) || out_ready;
    assign accept    = !rst && slot_free && found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    assign sel_din = req_din[int'(grant)*N +: N];
    assign sel_sh  = req_sh_amt[int'(grant)*SHW +: SHW];
    assign sel_dir = req_dir[grant];

    barrel_shifter_rotate #(.N(N), .SW(SHW)) u_rot (
        .din    (sel_din),
        .sh_amt (sel_sh),
        .dir    (sel_dir),
        .dout   (rot_dout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL:  if (accept) state_nxt = ST_FULL;
                      else if (out_ready) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    assign out_valid = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_dout <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_dout <= rot_dout;
                out_id   <= grant;
                rr_ptr   <= grant + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rotate_req_scheduler.sv
module tb_rotate_req_scheduler;
    localparam int N = 8, NREQ = 4, SW = 3, IW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready, req_dir;
    logic [NREQ*N-1:0]    req_din;
    logic [NREQ*SW-1:0]   req_sh_amt;
    logic                 out_valid, out_ready;
    logic [N-1:0]         out_dout;
    logic [IW-1:0]        out_id;

    rotate_req_scheduler #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din(req_din), .req_sh_amt(req_sh_amt), .req_dir(req_dir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dout(out_dout), .out_id(out_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  d;
        logic [IW-1:0] id;
    } res_t;

    res_t          sb[$];
    logic [IW-1:0] xfer_log[$];
    int            checks = 0, passes = 0, fails = 0;
    bit            m_full = 1'b0;
    logic [IW-1:0] m_ptr = '0;

    function automatic logic [N-1:0] rot_model(logic [N-1:0] d, int s, bit r);
        logic [N-1:0] o;
        o = '0;
        for (int i = 0; i < N; i++) begin
            if (!r) o[(i + s) % N] = d[i];
            else    o[i] = d[(i + s) % N];
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [N-1:0] d, input logic [SW-1:0] s, input logic r);
        req_din[i*N +: N]     = d;
        req_sh_amt[i*SW +: SW] = s;
        req_dir[i]            = r;
    endtask

    // One clock: check handshakes/outputs at the falling edge, update the
    // model at the rising edge, then drop the valid bit of an accepted command.
    task automatic cyc();
        int              g;
        logic [NREQ-1:0] exp_rdy;
        bit              hit;
        @(negedge clk);
        g = 0; hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(m_ptr) + k) % NREQ;
            if (!hit && req_valid[idx]) begin g = idx; hit = 1'b1; end
        end
        exp_rdy = '0;
        if (!rst && hit && (!m_full || out_ready)) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full && sb.size() > 0) begin
            chk("out_dout", 32'(out_dout), 32'(sb[0].d));
            chk("out_id", 32'(out_id), 32'(sb[0].id));
        end
        if (out_valid && out_ready && !rst) xfer_log.push_back(out_id);
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0; m_ptr = '0; sb.delete();
        end else begin
            if (m_full && out_ready) void'(sb.pop_front());
            if (exp_rdy != '0) begin
                sb.push_back('{d: rot_model(req_din[g*N +: N], int'(req_sh_amt[g*SW +: SW]), req_dir[g]),
                               id: IW'(g)});
                m_ptr  = IW'(g + 1);
                m_full = 1'b1;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
        #1;
        req_valid = req_valid & ~exp_rdy;
    endtask

    initial begin
        logic [N-1:0]  held_d;
        logic [IW-1:0] held_id;

        rst = 1'b1; out_ready = 1'b0; req_valid = '1;
        req_din = '0; req_sh_amt = '0; req_dir = '0;
        cyc(); cyc();
        rst = 1'b0; req_valid = '0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_dout", 32'(out_dout), 0);
        chk("rst_id", 32'(out_id), 0);

        // single left rotate, then drain
        out_ready = 1'b1;
        set_req(0, 8'b10110011, 3'd3, 1'b0);
        req_valid = 4'b0001; cyc();
        chk("t1_dout", 32'(out_dout), 32'(8'b10011101));
        chk("t1_id", 32'(out_id), 0);
        chk("t1_valid", 32'(out_valid), 1);
        cyc();
        chk("t1_empty", 32'(out_valid), 0);

        // right rotate and zero rotate
        set_req(1, 8'b10110011, 3'd2, 1'b1);
        req_valid = 4'b0010; cyc();
        chk("t2_right", 32'(out_dout), 32'(8'b11101100));
        cyc();
        set_req(2, 8'b10110011, 3'd0, 1'b1);
        req_valid = 4'b0100; cyc();
        chk("t2_zero", 32'(out_dout), 32'(8'b10110011));
        cyc();

        // all requesters busy: one grant per cycle in rotation (pointer is 3 here)
        for (int i = 0; i < NREQ; i++)
            set_req(i, N'($urandom), SW'($urandom), 1'($urandom));
        xfer_log.delete();
        for (int c = 0; c < 10; c++) begin
            req_valid = '1; cyc();
        end
        req_valid = '0; cyc();
        chk("t3_count", 32'(xfer_log.size()), 10);
        if (xfer_log.size() > 0) chk("t3_first", 32'(xfer_log[0]), 3);
        for (int i = 1; i < xfer_log.size(); i++)
            chk("t3_rotation", 32'(xfer_log[i]), 32'(IW'(xfer_log[i-1] + 1'b1)));

        // backpressure
        req_valid = '1; cyc();
        out_ready = 1'b0;
        held_d = out_dout; held_id = out_id;
        for (int c = 0; c < 5; c++) begin
            req_valid = '1; cyc();
            chk("t4_hold_dout", 32'(out_dout), 32'(held_d));
            chk("t4_hold_id", 32'(out_id), 32'(held_id));
            chk("t4_ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1; cyc();
        chk("t4_next_id", 32'(out_id), 32'(IW'(held_id + 1'b1)));
        req_valid = '0; cyc(); cyc();

        // sparse requests with pointer at 1, idle cycles keep the pointer
        req_valid = 4'b0001; cyc(); cyc();
        req_valid = 4'b0101; cyc();
        chk("t5_grant2", 32'(out_id), 2);
        cyc();
        chk("t5_grant0", 32'(out_id), 0);
        req_valid = '0; cyc(); cyc(); cyc();
        req_valid = '1; cyc();
        chk("t5_idle_ptr", 32'(out_id), 1);
        req_valid = '0; cyc();

        // reset while holding a stalled result
        req_valid = 4'b1000; cyc();
        out_ready = 1'b0; req_valid = '1; cyc();
        rst = 1'b1; cyc();
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_id", 32'(out_id), 0);
        chk("t6_dout", 32'(out_dout), 0);
        rst = 1'b0; out_ready = 1'b1; req_valid = '1; cyc();
        chk("t6_first", 32'(out_id), 0);
        req_valid = '0; cyc(); cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
